// File: rtl/ssp_pkg.sv
// Shared constants for the synchronous serial port transmit and receive FIFOs.
package ssp_pkg;

   localparam int SSP_WORD_W     = 8;
   localparam int SSP_FIFO_DEPTH = 4;
   localparam int SSP_PTR_W      = $clog2(SSP_FIFO_DEPTH);
   localparam int SSP_CNT_W      = SSP_PTR_W + 1;

endpackage

// File: rtl/ssp_fifo_core.sv
// Generic FIFO storage with wrap-around pointers and an occupancy count.
// The head word is always visible on rdata, with no read latency.
module ssp_fifo_core
   import ssp_pkg::*;
#(
   parameter int WIDTH = SSP_WORD_W,
   parameter int DEPTH = SSP_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             pop_ok;
   logic             push_ok;

   // A pop from a full queue frees the slot that a same-cycle push then takes.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: bus-side push decode, zero-masked head word for the
// serialiser, and a full-queue interrupt to the processor.
module ssp_tx_fifo
   import ssp_pkg::*;
#(
   parameter int WIDTH = SSP_WORD_W,
   parameter int DEPTH = SSP_FIFO_DEPTH
) (
   input  logic             PCLK,
   input  logic             CLEAR_B,
   input  logic             PSEL,
   input  logic             PWRITE,
   input  logic [WIDTH-1:0] PWDATA,
   input  logic             TxNextWord,
   output logic [WIDTH-1:0] TxData,
   output logic             TxValidWord,
   output logic             TxIsEmpty,
   output logic             SSPTXINTR
);

   logic             push;
   logic [WIDTH-1:0] head;
   logic             full;
   logic             empty;

   assign push = PSEL && PWRITE;

   ssp_fifo_core #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_core (
      .clk   (PCLK),
      .rst_n (CLEAR_B),
      .push  (push),
      .pop   (TxNextWord),
      .wdata (PWDATA),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // Stale storage must never reach the serialiser when nothing is queued.
   assign TxIsEmpty   = empty;
   assign TxValidWord = !empty;
   assign TxData      = empty ? '0 : head;
   assign SSPTXINTR   = full;

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Bench for ssp_tx_fifo: directed scenarios then random traffic, all checked
// against a queue-based model of the FIFO behaviour.
module tb_ssp_tx_fifo;

   localparam int DEPTH = 4;

   logic       PCLK = 1'b0;
   logic       CLEAR_B;
   logic       PSEL;
   logic       PWRITE;
   logic [7:0] PWDATA;
   logic       TxNextWord;
   logic [7:0] TxData;
   logic       TxValidWord;
   logic       TxIsEmpty;
   logic       SSPTXINTR;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q[$];

   always #5 PCLK = ~PCLK;

   ssp_tx_fifo dut (
      .PCLK        (PCLK),
      .CLEAR_B     (CLEAR_B),
      .PSEL        (PSEL),
      .PWRITE      (PWRITE),
      .PWDATA      (PWDATA),
      .TxNextWord  (TxNextWord),
      .TxData      (TxData),
      .TxValidWord (TxValidWord),
      .TxIsEmpty   (TxIsEmpty),
      .SSPTXINTR   (SSPTXINTR)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] exp_data;
      exp_data = (q.size() == 0) ? 8'h00 : q[0];
      chk({tag, "/empty"}, {7'd0, TxIsEmpty},   {7'd0, q.size() == 0});
      chk({tag, "/valid"}, {7'd0, TxValidWord}, {7'd0, q.size() != 0});
      chk({tag, "/intr"},  {7'd0, SSPTXINTR},   {7'd0, q.size() == DEPTH});
      chk({tag, "/data"},  TxData,              exp_data);
   endtask

   // One clock: inputs applied at a falling edge, model updated at the rising
   // edge, outputs compared at the following falling edge.
   task automatic cycle(input bit sel, input bit wr, input logic [7:0] d,
                        input bit pop, input string tag);
      bit did_pop;
      bit did_push;
      PSEL       = sel;
      PWRITE     = wr;
      PWDATA     = d;
      TxNextWord = pop;
      @(posedge PCLK);
      did_pop  = pop && (q.size() > 0);
      did_push = sel && wr && ((q.size() < DEPTH) || did_pop);
      if (did_pop)  void'(q.pop_front());
      if (did_push) q.push_back(d);
      @(negedge PCLK);
      PSEL       = 1'b0;
      PWRITE     = 1'b0;
      TxNextWord = 1'b0;
      check_model(tag);
   endtask

   task automatic push(input logic [7:0] d, input string tag);
      cycle(1'b1, 1'b1, d, 1'b0, tag);
   endtask

   task automatic pop(input string tag);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, tag);
   endtask

   initial begin
      CLEAR_B    = 1'b0;
      PSEL       = 1'b0;
      PWRITE     = 1'b0;
      PWDATA     = 8'h00;
      TxNextWord = 1'b0;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      CLEAR_B = 1'b1;
      check_model("reset");
      cycle(1'b0, 1'b0, 8'h00, 1'b0, "idle");
      chk("reset_data", TxData, 8'h00);

      // Basic push then pop
      push(8'hA5, "push_a5");
      chk("head_a5", TxData, 8'hA5);
      push(8'h3C, "push_3c");
      pop("pop1");
      chk("head_3c", TxData, 8'h3C);
      pop("pop2");
      chk("empty_after_pops", {7'd0, TxIsEmpty}, 8'h01);

      // Fill, overflow dropped, drain
      push(8'h11, "fill1");
      push(8'h22, "fill2");
      push(8'h33, "fill3");
      push(8'h44, "fill4");
      chk("intr_full", {7'd0, SSPTXINTR}, 8'h01);
      push(8'h55, "overflow");
      pop("drain1"); chk("drain1_head", TxData, 8'h22);
      pop("drain2"); chk("drain2_head", TxData, 8'h33);
      pop("drain3"); chk("drain3_head", TxData, 8'h44);
      pop("drain4"); chk("drain4_head", TxData, 8'h00);

      // PSEL without PWRITE is not a push
      cycle(1'b1, 1'b0, 8'h66, 1'b0, "read_sel");

      // Wrap-around with a shallow queue
      push(8'h01, "wrap_first");
      for (int i = 2; i <= 10; i++) begin
         cycle(1'b1, 1'b1, 8'(i), 1'b1, "wrap");
         chk("wrap_head", TxData, 8'(i));
      end
      pop("wrap_last");

      // Simultaneous push and pop on a full queue
      push(8'h11, "full2_1");
      push(8'h22, "full2_2");
      push(8'h33, "full2_3");
      push(8'h44, "full2_4");
      cycle(1'b1, 1'b1, 8'h99, 1'b1, "full_pushpop");
      chk("full_pushpop_intr", {7'd0, SSPTXINTR}, 8'h01);
      chk("full_pushpop_head", TxData, 8'h22);
      pop("fd1"); chk("fd1_head", TxData, 8'h33);
      pop("fd2"); chk("fd2_head", TxData, 8'h44);
      pop("fd3"); chk("fd3_head", TxData, 8'h99);
      pop("fd4");

      // Simultaneous push and pop on an empty queue: push only
      cycle(1'b1, 1'b1, 8'h7E, 1'b1, "empty_pushpop");
      chk("empty_pushpop_head", TxData, 8'h7E);
      pop("clean");

      // Asynchronous reset mid-cycle with a push in flight
      push(8'hC1, "pre_rst1");
      push(8'hC2, "pre_rst2");
      push(8'hC3, "pre_rst3");
      PSEL   = 1'b1;
      PWRITE = 1'b1;
      PWDATA = 8'h77;
      #2 CLEAR_B = 1'b0;
      #1;
      q.delete();
      check_model("rst_async");
      @(posedge PCLK);
      @(negedge PCLK);
      PSEL    = 1'b0;
      PWRITE  = 1'b0;
      CLEAR_B = 1'b1;
      check_model("rst_release");
      pop("pop_on_empty");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               8'($urandom), 1'($urandom_range(0, 1)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssp_tx_fifo.md
# ssp_tx_fifo

Transmit FIFO for the synchronous serial port. It accepts 8-bit words written by the processor bus and holds them in a small first-word-fall-through queue. It presents the head word to the serialiser (`ssp_tx_rx`) through `TxData`, `TxValidWord` and `TxIsEmpty`, and pops one word each time the serialiser pulses `TxNextWord`. It also raises `SSPTXINTR` to the processor whenever the queue is full.

## Interface
- `WIDTH`, default 8: word width in bits; must match the serialiser shift register.
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `PCLK` input, 1: system clock; all state changes on its rising edge.
- `CLEAR_B` input, 1: reset, asynchronous and active-low; clears all state immediately.
- `PSEL` input, 1: SSP selected by the bus.
- `PWRITE` input, 1: bus write strobe; a push request is `PSEL && PWRITE`.
- `PWDATA` input, WIDTH: word to push.
- `TxNextWord` input, 1: pop request from the serialiser; one PCLK cycle wide.
- `TxData` output, WIDTH: head-of-queue word; 0 when the queue is empty.
- `TxValidWord` output, 1: `TxData` holds a real queued word (not empty).
- `TxIsEmpty` output, 1: queue holds 0 words.
- `SSPTXINTR` output, 1: queue holds DEPTH words (full); this is the processor interrupt.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wr_ptr`, read pointer `rd_ptr`, and occupancy `count`.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally (DEPTH−1 → 0).
  - `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push, when `PSEL && PWRITE`:
  - If not full: `mem[wr_ptr] <= PWDATA`, `wr_ptr` increments.
  - If full and no pop this cycle: the word is dropped silently; no state changes.
- Pop, when `TxNextWord`:
  - If not empty: `rd_ptr` increments.
  - If empty: ignored; pointers and count are unchanged.
- Simultaneous push and pop:
  - When not empty and not full: both occur and `count` is unchanged.
  - When full: both occur; the pop frees the slot, so the push is accepted and `count` stays at DEPTH.
  - When empty: only the push occurs and `count` becomes 1. The pushed word is not popped.
- Count update: +1 on push-only, −1 on pop-only, 0 on both or neither.
- Output decode, all combinational from registered state:
  - `TxIsEmpty = (count == 0)`
  - `TxValidWord = ~TxIsEmpty`
  - `SSPTXINTR = (count == DEPTH)`
  - `TxData = TxIsEmpty ? 0 : mem[rd_ptr]`
- The block does not interpret serial timing. The serialiser guarantees that `TxNextWord` is at most one cycle wide per word.

## Timing
- Reset (`CLEAR_B` low) acts asynchronously: pointers = 0, `count` = 0, memory contents = 0.
  - Resulting outputs: `TxData` = 0, `TxValidWord` = 0, `TxIsEmpty` = 1, `SSPTXINTR` = 0.
  - Reset while a push or pop is in flight discards it; the first edge after deassertion sees an empty queue.
- Push latency: a word pushed at edge N appears on `TxData` (if the queue was empty) and `TxIsEmpty` falls after edge N. It is therefore visible to the serialiser's state logic during cycle N+1.
- Pop latency: a `TxNextWord` sampled high at edge N advances `TxData` to the next word after edge N.
  - The serialiser captures `TxData` on that same edge N, so the captured word is the pre-pop head.
- `SSPTXINTR` rises the cycle after the push that fills the queue. It falls the cycle after the first pop from a full queue, unless that pop was paired with a push.
- No combinational path runs from any input to any output.

## Structure
- Package `ssp_pkg` holds the shared constants:
  - `SSP_WORD_W = 8` and `SSP_FIFO_DEPTH = 4`.
  - Derived `SSP_PTR_W = 2` and `SSP_CNT_W = 3`.
  - The receive FIFO uses the same constants.
- Sub-module `ssp_fifo_core` is the natural split. It holds the generic storage, pointers and count, with push/pop/full/empty ports and no bus decode. It is reused unchanged by the future receive FIFO.
- `ssp_tx_fifo` adds the bus push decode, zero-masking of `TxData` when empty, and `SSPTXINTR`.

## Test plan
- Reset, then no activity → `TxIsEmpty` = 1, `TxValidWord` = 0, `TxData` = 0x00, `SSPTXINTR` = 0.
- Push 0xA5, then 0x3C → after the first edge `TxData` = 0xA5 and `TxIsEmpty` = 0. Pulse `TxNextWord` → `TxData` = 0x3C. Pulse again → `TxIsEmpty` = 1, `TxData` = 0x00.
- Push 0x11, 0x22, 0x33, 0x44 → `SSPTXINTR` = 1. Push 0x55 → dropped. Then 4 pops → `TxData` sequence is 0x11, 0x22, 0x33, 0x44, then empty. 0x55 never appears.
- Wrap-around: push and pop 10 words (0x01..0x0A) with at most 2 outstanding → output order is 0x01..0x0A and pointers cross 3 → 0 without loss.
- Full queue (0x11..0x44), simultaneous push 0x99 and pop → `SSPTXINTR` stays 1 and `TxData` = 0x22. Draining yields 0x22, 0x33, 0x44, 0x99.
- Three words queued, assert `CLEAR_B` low mid-cycle, concurrent with a push → outputs return to reset values immediately. After release, pop on empty → no change.
